// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA burst/aligner types, widths and the burst-splitter FSM encoding.
package dma_pkg;
    localparam int DMA_DATA_WIDTH   = 512;
    localparam int DMA_ADDR_WIDTH   = 32;
    localparam int DMA_STRB_WIDTH   = DMA_DATA_WIDTH / 8;
    localparam int DMA_OFFSET_WIDTH = $clog2(DMA_STRB_WIDTH);
    localparam int BOUNDARY_4K      = 4096;

    typedef logic [7:0]                  axi_len_t;
    typedef logic [DMA_OFFSET_WIDTH-1:0] bytes_offset_t;
    typedef logic [DMA_ADDR_WIDTH-1:0]   dma_addr_t;

    typedef struct packed {
        dma_addr_t     addr;
        axi_len_t      alen;
        bytes_offset_t head;
        bytes_offset_t tail;
    } s_dma_burst_req_t;

    typedef struct packed {
        bytes_offset_t head;
        bytes_offset_t tail;
        axi_len_t      alen;
        logic          valid;
    } s_dma_aligner_req_t;

    typedef enum logic [1:0] {BURST_IDLE, BURST_CALC, BURST_REQ, BURST_DONE} burst_state_e;
endpackage

// File: rtl/dma_burst_calc.sv
// dma_burst_calc: sizes the next INCR burst from {addr, rem}, limited by MAX_BEATS, 4 KiB and rem.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  rem,
    output logic [LEN_WIDTH-1:0]  n,
    output axi_len_t              alen,
    output bytes_offset_t         head,
    output bytes_offset_t         tail,
    output logic [ADDR_WIDTH-1:0] aligned_addr
);
    localparam int StrbWidth   = DATA_WIDTH / 8;
    localparam int OffsetWidth = $clog2(StrbWidth);
    localparam int W           = LEN_WIDTH + 1;

    logic [OffsetWidth-1:0] off;
    logic [W-1:0] rem_w, b4k, bmax, n_a, n_w, end_w;

    assign off   = addr[OffsetWidth-1:0];
    assign rem_w = {1'b0, rem};
    assign b4k   = W'(BOUNDARY_4K) - W'(addr[11:0]);
    assign bmax  = W'(MAX_BEATS * StrbWidth) - W'(off);
    assign n_a   = rem_w < b4k ? rem_w : b4k;
    assign n_w   = n_a < bmax ? n_a : bmax;
    assign end_w = W'(off) + n_w;

    assign n            = n_w[LEN_WIDTH-1:0];
    assign alen         = axi_len_t'(((end_w + W'(StrbWidth - 1)) >> OffsetWidth) - W'(1));
    assign head         = bytes_offset_t'(off);
    // Bytes unused in the last beat: distance from the end pointer up to the next beat boundary.
    assign tail         = bytes_offset_t'(-end_w[OffsetWidth-1:0]);
    assign aligned_addr = addr & ~ADDR_WIDTH'(StrbWidth - 1);
endmodule

// File: rtl/dma_burst_splitter.sv
// dma_burst_splitter: splits one descriptor side into AXI4 INCR bursts with aligner info pulses.
// Optional DMA_BURST_SPLITTER_STATS_EN adds saturating burst/stall counters.
module dma_burst_splitter
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  go_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output s_dma_burst_req_t      req_o,
    output s_dma_aligner_req_t    info_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef DMA_BURST_SPLITTER_STATS_EN
    ,
    output logic [31:0]           burst_cnt_o,
    output logic [31:0]           stall_cnt_o
`endif
);
    burst_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, c_addr;
    logic [LEN_WIDTH-1:0]  rem_q, c_n;
    axi_len_t              c_alen;
    bytes_offset_t         c_head, c_tail;
    s_dma_burst_req_t      req_q;
    logic                  accept;

    dma_burst_calc #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) u_calc (
        .addr        (addr_q),
        .rem         (rem_q),
        .n           (c_n),
        .alen        (c_alen),
        .head        (c_head),
        .tail        (c_tail),
        .aligned_addr(c_addr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            BURST_IDLE: state_d = go_i ? (len_i == '0 ? BURST_DONE : BURST_CALC) : BURST_IDLE;
            BURST_CALC: state_d = BURST_REQ;
            BURST_REQ:  state_d = req_ready_i ? (rem_q == '0 ? BURST_DONE : BURST_CALC) : BURST_REQ;
            default:    state_d = BURST_IDLE;
        endcase
    end

    // rem_q already excludes the burst in flight, so it decides CALC vs DONE on accept.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q <= BURST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == BURST_IDLE && go_i) begin
                addr_q <= addr_i;
                rem_q  <= len_i;
            end
            if (state_q == BURST_CALC) begin
                req_q  <= '{addr: c_addr, alen: c_alen, head: c_head, tail: c_tail};
                addr_q <= addr_q + ADDR_WIDTH'(c_n);
                rem_q  <= rem_q - c_n;
            end
        end
    end

    assign req_valid_o = state_q == BURST_REQ;
    assign accept      = req_valid_o & req_ready_i;
    assign req_o       = req_q;
    assign info_o      = '{head: req_q.head, tail: req_q.tail, alen: req_q.alen, valid: accept};
    assign busy_o      = state_q != BURST_IDLE;
    assign done_o      = state_q == BURST_DONE;

`ifdef DMA_BURST_SPLITTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            burst_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (accept && burst_cnt_o != '1) burst_cnt_o <= burst_cnt_o + 32'd1;
            if (req_valid_o && !req_ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dma_burst_splitter.sv
// tb_dma_burst_splitter: directed bench with an arithmetic burst model and a per-cycle compare process.
module tb_dma_burst_splitter;
    import dma_pkg::*;

    logic clk = 0, rst = 1, clear_i = 0, go_i = 0, req_ready_i = 1;
    logic [31:0] addr_i = '0, len_i = '0;
    logic req_valid_o, busy_o, done_o;
    s_dma_burst_req_t req_o;
    s_dma_aligner_req_t info_o;
`ifdef DMA_BURST_SPLITTER_STATS_EN
    logic [31:0] burst_cnt_o, stall_cnt_o;
`endif

    always #5 clk = ~clk;

    dma_burst_splitter dut (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_i),
        .go_i       (go_i),
        .addr_i     (addr_i),
        .len_i      (len_i),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .req_o      (req_o),
        .info_o     (info_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef DMA_BURST_SPLITTER_STATS_EN
        ,
        .burst_cnt_o(burst_cnt_o),
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    int errors = 0, checks = 0;
    int cyc = 0, last_acc = 0, last_gap = 0, done_cnt = 0;
    s_dma_burst_req_t exp_q[$], cap_q[$];
    s_dma_burst_req_t prev_req;
    logic prev_pend = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected burst list from the byte-level rules: each burst stops at the earliest of
    // the remaining length, the next 4 KiB page and 16 beats of 64 bytes.
    function automatic void model(input longint addr, input longint len);
        longint a, r, off, b4k, bmax, n, e;
        a = addr;
        r = len;
        while (r > 0) begin
            off  = a % 64;
            b4k  = 4096 - (a % 4096);
            bmax = 16 * 64 - off;
            n    = r;
            if (b4k < n) n = b4k;
            if (bmax < n) n = bmax;
            e = off + n;
            exp_q.push_back('{addr: 32'(a - off), alen: 8'((e + 63) / 64 - 1),
                              head: 6'(off), tail: 6'((64 - e % 64) % 64)});
            a += n;
            r -= n;
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) prev_pend = 0;
        else begin
            chk("info_valid", 64'(info_o.valid), 64'(req_valid_o & req_ready_i));
            if (req_valid_o && prev_pend) chk("req_stable", 64'(req_o), 64'(prev_req));
            if (req_valid_o && req_ready_i) begin
                chk("info_fields", 64'({info_o.head, info_o.tail, info_o.alen}),
                    64'({req_o.head, req_o.tail, req_o.alen}));
                if (exp_q.size() == 0) chk("extra_burst", 64'(exp_q.size()), 64'd1);
                else chk("burst", 64'(req_o), 64'(exp_q.pop_front()));
                cap_q.push_back(req_o);
                last_gap = cyc - last_acc;
                last_acc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                chk("done_pending", 64'(exp_q.size()), 64'd0);
            end
            prev_pend = req_valid_o && !req_ready_i;
            prev_req  = req_o;
        end
    end

    task automatic do_go(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk); #2;
        addr_i = a; len_i = l; go_i = 1;
        @(posedge clk); #2;
        go_i = 0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = done_o;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("busy_fall", 64'(busy_o), 64'd0);
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req_valid_o;
        end
        chk("valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] l, input int n_exp);
        cap_q.delete();
        model(a, l);
        do_go(a, l);
        @(negedge clk);
        chk("calc_no_valid", 64'(req_valid_o), 64'd0);
        chk("calc_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("valid_latency", 64'(req_valid_o), 64'd1);
        wait_done();
        chk("burst_count", 64'(cap_q.size()), 64'(n_exp));
    endtask

    task automatic abort(input logic use_rst);
        int d0;
        req_ready_i = 0;
        model(32'h3000, 32'd512);
        do_go(32'h3000, 32'd512);
        wait_valid();
        d0 = done_cnt;
        @(posedge clk); #2;
        if (use_rst) rst = 1; else clear_i = 1;
        @(posedge clk); #2;
        rst = 0; clear_i = 0;
        exp_q.delete();
        @(negedge clk);
        chk(use_rst ? "rst_idle" : "clr_idle", 64'({busy_o, req_valid_o}), 64'd0);
        chk(use_rst ? "rst_req" : "clr_req", 64'(req_o), 64'd0);
        req_ready_i = 1;
        repeat (5) @(negedge clk);
        chk(use_rst ? "rst_no_done" : "clr_no_done", 64'(done_cnt), 64'(d0));
`ifdef DMA_BURST_SPLITTER_STATS_EN
        chk("abort_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        int vcnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'({req_valid_o, busy_o, done_o, info_o.valid}), 64'd0);
        chk("rst_req_o", 64'(req_o), 64'd0);
        @(posedge clk); #2;
        rst = 0;

        run(32'h1000, 32'd256, 1);
        chk("t1_addr", 64'(cap_q[0].addr), 64'h1000);
        chk("t1_alen", 64'(cap_q[0].alen), 64'd3);

        run(32'h1005, 32'd100, 1);
        chk("t2_fields", 64'({cap_q[0].addr, cap_q[0].alen, cap_q[0].head, cap_q[0].tail}),
            64'({32'h1000, 8'd1, 6'd5, 6'd23}));

        run(32'h0FC0, 32'd128, 2);
        chk("t3_second", 64'({cap_q[1].addr, cap_q[1].alen}), 64'({32'h1000, 8'd0}));

        run(32'h2000, 32'd2048, 2);
        chk("t4_second", 64'({cap_q[1].addr, cap_q[1].alen}), 64'({32'h2400, 8'd15}));
        chk("t4_bubble", 64'(last_gap), 64'd2);

        run(32'h0FF3, 32'd3000, 4);
        chk("t_multi_head", 64'({cap_q[0].head, cap_q[0].tail}), 64'({6'd51, 6'd0}));
        chk("t_multi_last", 64'({cap_q[3].addr, cap_q[3].alen, cap_q[3].tail}),
            64'({32'h1800, 8'd14, 6'd21}));

        cap_q.delete();
        do_go(32'h5000, 32'd0);
        @(negedge clk);
        chk("len0_done", 64'({done_o, req_valid_o}), 64'b10);
        @(negedge clk);
        chk("len0_after", 64'({done_o, busy_o}), 64'd0);
        chk("len0_no_burst", 64'(cap_q.size()), 64'd0);

        @(posedge clk); #2;
        clear_i = 1;
        @(posedge clk); #2;
        clear_i = 0;
        cap_q.delete();
        req_ready_i = 0;
        model(32'h4010, 32'd64);
        do_go(32'h4010, 32'd64);
        wait_valid();
        repeat (3) @(posedge clk);
        #2 go_i = 1; addr_i = 32'h7000; len_i = 32'd4096;
        @(posedge clk); #2;
        go_i = 0;
        repeat (6) @(posedge clk);
        #2 req_ready_i = 1;
        wait_done();
        chk("t5_bursts", 64'(cap_q.size()), 64'd1);
        chk("t5_fields", 64'({cap_q[0].addr, cap_q[0].alen, cap_q[0].head, cap_q[0].tail}),
            64'({32'h4000, 8'd1, 6'd16, 6'd48}));
`ifdef DMA_BURST_SPLITTER_STATS_EN
        chk("t5_stall_cnt", 64'(stall_cnt_o), 64'd10);
        chk("t5_burst_cnt", 64'(burst_cnt_o), 64'd1);
`endif
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            vcnt += int'(req_valid_o);
        end
        chk("go_ignored", 64'(vcnt), 64'd0);

        abort(1'b0);
        abort(1'b1);
        run(32'h1000, 32'd64, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
